// File: rtl/clk_gen_pkg.sv
// Shared types and defaults for the programmable clock generator controller.
// The config struct is shared by the shadow and active registers.
package clk_gen_pkg;

  localparam int CLK_GEN_PERIOD_W = 8;
  localparam int CLK_GEN_DEF_PERIOD = 10;
  localparam int CLK_GEN_DEF_HIGH = 5;
  localparam int CLK_GEN_DEF_PHASE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  typedef struct packed {
    logic [CLK_GEN_PERIOD_W-1:0] period;
    logic [CLK_GEN_PERIOD_W-1:0] high;
    logic [CLK_GEN_PERIOD_W-1:0] phase;
  } cfg_t;

endpackage

// File: rtl/clk_gen_phase_cmp.sv
// Phase comparator: shifts the period counter back by the phase offset (mod period)
// and reports whether the shifted count falls inside the high window.
module clk_gen_phase_cmp #(
  parameter int W = 8
) (
  input  logic [W-1:0] cnt,
  input  logic [W-1:0] phase,
  input  logic [W-1:0] period,
  input  logic [W-1:0] high,
  output logic         phase_hit
);

  logic [W:0] pcnt;

  // One extra bit keeps cnt+period-phase from wrapping before the compare.
  always_comb begin
    if (cnt >= phase) begin
      pcnt = {1'b0, cnt - phase};
    end else begin
      pcnt = {1'b0, cnt} + {1'b0, period} - {1'b0, phase};
    end
    phase_hit = (pcnt < {1'b0, high});
  end

endmodule

// File: rtl/clk_gen_ctrl.sv
// Runtime-programmable clock generator controller with glitch-free reconfiguration.
// Define CLK_GEN_CTRL_PHASE_OUT_EN to build the phase-shifted output; otherwise it is tied low.
module clk_gen_ctrl
  import clk_gen_pkg::*;
#(
  parameter int PERIOD_W   = CLK_GEN_PERIOD_W,
  parameter int DEF_PERIOD = CLK_GEN_DEF_PERIOD,
  parameter int DEF_HIGH   = CLK_GEN_DEF_HIGH,
  parameter int DEF_PHASE  = CLK_GEN_DEF_PHASE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [PERIOD_W-1:0] cfg_high,
  input  logic [PERIOD_W-1:0] cfg_phase,
  output logic                cfg_err,
  output logic                cfg_pending,
  output logic                busy,
  output logic                clk_out_ref,
  output logic                clk_out_phase
);

  state_t              state;
  logic [PERIOD_W-1:0] cnt;
  cfg_t                act;
  cfg_t                shd;
  logic                cfg_ok;
  logic                xfer;
  logic                wrap;
  logic                apply;
  logic                running;

  assign cfg_ready = !cfg_pending;
  assign xfer      = cfg_valid && !cfg_pending;
  assign wrap      = (cnt == (act.period - PERIOD_W'(1)));
  assign running   = (state != IDLE);
  // Shadow lands immediately when idle, otherwise only on a period boundary.
  assign apply     = cfg_pending && ((state == IDLE) || wrap);

  // The phase field is range-checked even when the phase output is not built.
  always_comb begin
    cfg_ok = (cfg_period >= PERIOD_W'(2)) &&
             (cfg_high != '0) &&
             (cfg_high < cfg_period) &&
             (cfg_phase < cfg_period);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act         <= '{period: PERIOD_W'(DEF_PERIOD),
                       high:   PERIOD_W'(DEF_HIGH),
                       phase:  PERIOD_W'(DEF_PHASE)};
      shd         <= '0;
      cfg_pending <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= xfer && !cfg_ok;
      if (apply) begin
        act         <= shd;
        cfg_pending <= 1'b0;
      end else if (xfer && cfg_ok) begin
        shd         <= '{period: cfg_period, high: cfg_high, phase: cfg_phase};
        cfg_pending <= 1'b1;
      end
    end
  end

`ifdef CLK_GEN_CTRL_PHASE_OUT_EN
  logic phase_hit;

  clk_gen_phase_cmp #(
    .W(PERIOD_W)
  ) u_phase_cmp (
    .cnt      (cnt),
    .phase    (act.phase),
    .period   (act.period),
    .high     (act.high),
    .phase_hit(phase_hit)
  );
`else
  logic unused_phase;
  assign unused_phase  = ^act.phase;
  assign clk_out_phase = 1'b0;
`endif

  // STOP keeps counting so the pulse in flight always completes its period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      busy          <= 1'b0;
      clk_out_ref   <= 1'b0;
`ifdef CLK_GEN_CTRL_PHASE_OUT_EN
      clk_out_phase <= 1'b0;
`endif
    end else begin
      clk_out_ref   <= running && (cnt < act.high);
`ifdef CLK_GEN_CTRL_PHASE_OUT_EN
      clk_out_phase <= running && phase_hit;
`endif
      case (state)
        IDLE: begin
          cnt <= '0;
          if (en) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          cnt <= wrap ? '0 : cnt + PERIOD_W'(1);
          if (!en) begin
            state <= STOP;
          end
        end
        STOP: begin
          cnt <= wrap ? '0 : cnt + PERIOD_W'(1);
          if (en) begin
            state <= RUN;
          end else if (wrap) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_gen_ctrl.sv
// Directed bench for clk_gen_ctrl: waveforms are hand-written '0'/'1' strings per output cycle.
// Phase expectations apply only when CLK_GEN_CTRL_PHASE_OUT_EN is defined; otherwise phase must be 0.
module tb_clk_gen_ctrl;

  localparam int PW = 8;
`ifdef CLK_GEN_CTRL_PHASE_OUT_EN
  localparam bit PHASE_ON = 1'b1;
`else
  localparam bit PHASE_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [PW-1:0] cfg_period;
  logic [PW-1:0] cfg_high;
  logic [PW-1:0] cfg_phase;
  logic          cfg_err;
  logic          cfg_pending;
  logic          busy;
  logic          clk_out_ref;
  logic          clk_out_phase;

  int checks = 0;
  int errors = 0;

  clk_gen_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_period   (cfg_period),
    .cfg_high     (cfg_high),
    .cfg_phase    (cfg_phase),
    .cfg_err      (cfg_err),
    .cfg_pending  (cfg_pending),
    .busy         (busy),
    .clk_out_ref  (clk_out_ref),
    .clk_out_phase(clk_out_phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One character per output cycle; phase pattern is ignored when the feature is off.
  task automatic expect_wave(input string tag, input string rp, input string pp);
    for (int i = 0; i < rp.len(); i++) begin
      tick();
      check({tag, "_ref"}, 32'(clk_out_ref), 32'(rp[i] == "1"));
      check({tag, "_ph"}, 32'(clk_out_phase), 32'((pp[i] == "1") && PHASE_ON));
    end
  endtask

  task automatic offer(input int p, input int h, input int ph);
    cfg_period = PW'(p);
    cfg_high   = PW'(h);
    cfg_phase  = PW'(ph);
    cfg_valid  = 1'b1;
  endtask

  int inv_p[3]  = '{5, 1, 6};
  int inv_h[3]  = '{5, 1, 3};
  int inv_ph[3] = '{0, 0, 6};

  initial begin
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0;
    cfg_period = '0; cfg_high = '0; cfg_phase = '0;
    tick(); tick();
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_pending", 32'(cfg_pending), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(cfg_err), 32'd0);
    check("rst_ref", 32'(clk_out_ref), 32'd0);
    check("rst_ph", 32'(clk_out_phase), 32'd0);
    rst_n = 1'b1;

    // Defaults 10/5/4 running for three periods.
    en = 1'b1;
    tick();
    check("en_busy", 32'(busy), 32'd1);
    check("en_ref0", 32'(clk_out_ref), 32'd0);
    expect_wave("def", "111110000011111000001111100000", "000011111000001111100000111110");

    // 8/2/0 offered at cnt=0: old period finishes, then the new one takes over.
    offer(8, 2, 0);
    tick();
    cfg_valid = 1'b0;
    check("acc_pending", 32'(cfg_pending), 32'd1);
    check("acc_ready", 32'(cfg_ready), 32'd0);
    check("acc_err", 32'(cfg_err), 32'd0);
    check("acc_ref", 32'(clk_out_ref), 32'd1);
    expect_wave("old", "11110000", "00011111");
    check("old_pending", 32'(cfg_pending), 32'd1);
    expect_wave("wrap", "0", "0");
    check("wrap_pending", 32'(cfg_pending), 32'd0);
    expect_wave("new", "1100000011000000", "1100000011000000");

    // Invalid configs are rejected with a one-cycle error pulse.
    for (int n = 0; n < 3; n++) begin
      offer(inv_p[n], inv_h[n], inv_ph[n]);
      tick();
      cfg_valid = 1'b0;
      check("inv_err", 32'(cfg_err), 32'd1);
      check("inv_pending", 32'(cfg_pending), 32'd0);
      check("inv_ref", 32'(clk_out_ref), 32'((2 * n) < 2));
      tick();
      check("inv_err_clr", 32'(cfg_err), 32'd0);
      check("inv_ref2", 32'(clk_out_ref), 32'((2 * n + 1) < 2));
    end
    expect_wave("inv_after", "0011000000", "0011000000");

    // Restore 10/5/4 through the handshake.
    offer(10, 5, 4);
    tick();
    cfg_valid = 1'b0;
    check("ld_pending", 32'(cfg_pending), 32'd1);
    expect_wave("ld", "1000000", "1000000");
    check("ld_applied", 32'(cfg_pending), 32'd0);

    // en dropped at cnt=2: period completes, then idle.
    expect_wave("stop_a", "11", "00");
    en = 1'b0;
    expect_wave("stop_b", "1110000", "0011111");
    check("stop_busy", 32'(busy), 32'd1);
    expect_wave("stop_c", "0", "0");
    check("stop_idle", 32'(busy), 32'd0);
    expect_wave("idle", "000", "000");
    check("idle_busy", 32'(busy), 32'd0);

    // en dropped at cnt=2 and re-raised at cnt=7: no gap.
    en = 1'b1;
    tick();
    check("re_busy", 32'(busy), 32'd1);
    check("re_ref0", 32'(clk_out_ref), 32'd0);
    expect_wave("re_a", "11", "00");
    en = 1'b0;
    expect_wave("re_b", "11100", "00111");
    en = 1'b1;
    expect_wave("re_c", "0001111100000", "1100000111110");
    check("re_busy2", 32'(busy), 32'd1);

    // Reset mid-pulse with a pending shadow.
    offer(8, 2, 0);
    tick();
    cfg_valid = 1'b0;
    check("pre_rst_pending", 32'(cfg_pending), 32'd1);
    check("pre_rst_ref", 32'(clk_out_ref), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ref", 32'(clk_out_ref), 32'd0);
    check("arst_ph", 32'(clk_out_phase), 32'd0);
    check("arst_pending", 32'(cfg_pending), 32'd0);
    check("arst_ready", 32'(cfg_ready), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_busy", 32'(busy), 32'd1);
    check("post_pending", 32'(cfg_pending), 32'd0);
    check("post_ref0", 32'(clk_out_ref), 32'd0);
    expect_wave("post", "11111000001111100000", "00001111100000111110");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
